alu_cmp_pipe: RTL and testbench
===============================

# alu_cmp_pipe

Pipelined, parametrised compare unit for the pipelined MIPS datapath. It evaluates the six branch/set conditions on two WIDTH-bit operands, in signed or unsigned mode, and returns a WIDTH-bit 0/1 result plus the internal flags. It runs behind a valid/ready handshake with a 2-stage pipeline, so it can sit between the ID/EX register and the EX/MEM writeback mux while stalls back up through it.

## Interface
- WIDTH, 32: operand and result width, ≥ 2.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all valid bits and registered outputs.
- flush  in  1  synchronous pipeline squash (branch mispredict); same effect as reset on pipeline state.
- in_valid  in  1  operand/command presented.
- in_ready  out  1  unit accepts this cycle.
- in_a, in_b  in  WIDTH  operands.
- in_fun  in  3  condition code: 001 EQ, 000 NE, 010 LT, 110 LEZ, 101 LTZ, 111 GTZ; others are invalid.
- in_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_s  out  WIDTH  {WIDTH-1 zeros, cond}.
- out_z, out_v, out_n  out  1  flags of the compare used for out_s.
- out_bad_fun  out  1  in_fun was invalid; out_s = 0.

## Operation
- Stage 1 (S1) registers in_a, in_b, in_fun and in_signed when a transfer occurs (in_valid & in_ready).
- Stage 2 (S2) computes the flags from the S1 registers and registers the flags, the cond bit and bad_fun.
- Compare operand: EQ/NE/LT use B = in_b. LEZ/LTZ/GTZ use B = 0 and ignore in_b.
- D = A − B, computed WIDTH+1 wide.
- Z = (D[WIDTH-1:0] == 0).
- V = signed overflow: A and B have different sign bits, and D[WIDTH-1] differs from the sign of A. In unsigned mode V = 0.
- N is the "A < B" flag: signed mode D[WIDTH-1] ^ V; unsigned mode the borrow, D[WIDTH].
- cond: EQ = Z; NE = ~Z; LT = N; LEZ = Z|N; LTZ = N; GTZ = ~(Z|N).
- Unsigned LTZ is always 0 and unsigned GTZ equals ~Z. This behaviour is intended and not an error.
- Invalid in_fun: cond = 0, bad_fun = 1, flags still reported.
- Pipeline control: S2 holds when out_valid & ~out_ready. S1 advances into S2 when S2 is empty or draining. in_ready = ~s1_valid | s1_advance.
- in_ready is combinational from out_ready. This path is accepted.

## Timing
- Latency: an operand accepted at edge k appears with out_valid high after edge k+2, assuming no stall.
- Throughput: 1 per cycle when out_ready is held high.
- Handshake: out_s, out_z, out_v, out_n and out_bad_fun stay stable while out_valid & ~out_ready. in_* are sampled only on a transfer.
- Reset values: out_valid = 0, out_s = 0, out_z = 0, out_v = 0, out_n = 0, out_bad_fun = 0.
- in_ready = 1 in the first cycle after reset deasserts.
- reset or flush mid-stream clears s1_valid and s2_valid on that edge. An input presented in the same cycle as flush is dropped, even though in_ready may read 1.
- reset has priority over flush. Data registers need not be cleared on flush, only the valid bits; the output data registers are zeroed on reset.
- Simultaneous output drain and input accept with both stages full: both stages advance and no bubble is inserted.

## Structure
- Package alu_cmp_pkg:
  - typedef cmp_fun_t holding the six condition encodings as named constants.
  - function is_valid_fun.
- Sub-module alu_cmp_eval: combinational; takes A, B, fun and signed; produces z, v, n, cond and bad. It is reused by the S2 logic and instantiated directly by the bench as a reference model.
- The top level holds the two stage registers and the handshake logic.

## Test plan
- WIDTH=32, signed, LT, A=0xFFFFFFFF (−1), B=1 → out_s=1, n=1, v=0, at edge k+2.
- Same operands in unsigned mode → out_s=0, n=0 (0xFFFFFFFF > 1).
- Signed LT with overflow: A=0x80000000, B=1 → v=1, n=1, out_s=1. Signed GTZ, A=0x7FFFFFFF → out_s=1.
- Back-to-back stream of 8 EQ/NE ops with out_ready toggled 1,0,0,1… → results in order, none lost or duplicated, out_* stable during stall, in_ready low while both stages are full and stalled.
- flush asserted with both stages full → out_valid=0 next cycle, the following op emerges 2 cycles after its accept. Reset mid-stream → all outputs 0 and in_ready=1.
- in_fun=011 → out_s=0, out_bad_fun=1. WIDTH=8, unsigned LEZ, A=0x00 → out_s=1, z=1.

Source files
------------

// File: rtl/alu_cmp_pkg.sv
// rtl/alu_cmp_pkg.sv - shared condition encodings and helpers for the compare unit
// Purpose: condition-code enum and fun validity check used by alu_cmp_eval and alu_cmp_pipe.
// Contents: cmp_fun_t (six condition encodings), is_valid_fun().
package alu_cmp_pkg;

   typedef enum logic [2:0] {
      FUN_NE  = 3'b000,
      FUN_EQ  = 3'b001,
      FUN_LT  = 3'b010,
      FUN_LTZ = 3'b101,
      FUN_LEZ = 3'b110,
      FUN_GTZ = 3'b111
   } cmp_fun_t;

   function automatic logic is_valid_fun(input logic [2:0] fun);
      case (fun)
         FUN_NE, FUN_EQ, FUN_LT, FUN_LTZ, FUN_LEZ, FUN_GTZ: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_cmp_pipe_if.sv
// rtl/alu_cmp_pipe_if.sv - operand/result handshake bundle for the compare pipe
// Purpose: groups the input handshake (in_*) and output handshake (out_*) of alu_cmp_pipe.
// Modports: master = producer/consumer side (testbench, datapath), slave = compare unit.
interface alu_cmp_pipe_if #(parameter int WIDTH = 32);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_fun;
   logic             in_signed;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_s;
   logic             out_z;
   logic             out_v;
   logic             out_n;
   logic             out_bad_fun;

   modport master (
      output in_valid, in_a, in_b, in_fun, in_signed, out_ready,
      input  in_ready, out_valid, out_s, out_z, out_v, out_n, out_bad_fun
   );

   modport slave (
      input  in_valid, in_a, in_b, in_fun, in_signed, out_ready,
      output in_ready, out_valid, out_s, out_z, out_v, out_n, out_bad_fun
   );

endinterface

// File: rtl/alu_cmp_eval.sv
// rtl/alu_cmp_eval.sv - combinational compare: flags and condition bit for one operand pair
// Purpose: computes Z/V/N from A-B (B forced to 0 for zero-compare conditions) and selects cond.
// Ports: a_i, b_i (WIDTH) operands; fun_i (3) condition code; signed_i compare mode;
//        z_o, v_o, n_o flags; cond_o selected condition; bad_o fun_i not a valid code.
module alu_cmp_eval
   import alu_cmp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       fun_i,
   input  logic             signed_i,
   output logic             z_o,
   output logic             v_o,
   output logic             n_o,
   output logic             cond_o,
   output logic             bad_o
);

   logic             zero_cmp;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   diff;

   always_comb begin
      zero_cmp = (fun_i == FUN_LEZ) || (fun_i == FUN_LTZ) || (fun_i == FUN_GTZ);
      b_eff    = zero_cmp ? '0 : b_i;
      // One extra bit so diff[WIDTH] is the unsigned borrow.
      diff     = {1'b0, a_i} - {1'b0, b_eff};
      z_o      = (diff[WIDTH-1:0] == '0);
      v_o      = signed_i & (a_i[WIDTH-1] != b_eff[WIDTH-1]) & (diff[WIDTH-1] != a_i[WIDTH-1]);
      n_o      = signed_i ? (diff[WIDTH-1] ^ v_o) : diff[WIDTH];
      bad_o    = ~is_valid_fun(fun_i);
      cond_o   = 1'b0;
      case (fun_i)
         FUN_EQ:          cond_o = z_o;
         FUN_NE:          cond_o = ~z_o;
         FUN_LT, FUN_LTZ: cond_o = n_o;
         FUN_LEZ:         cond_o = z_o | n_o;
         FUN_GTZ:         cond_o = ~(z_o | n_o);
         default:         cond_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_cmp_pipe.sv
// rtl/alu_cmp_pipe.sv - two-stage valid/ready pipelined compare unit
// Purpose: S1 captures operands on a transfer, S2 registers flags/cond from alu_cmp_eval.
// Ports: clk; reset (sync, active-high); flush (sync squash of both valid bits);
//        bus (alu_cmp_pipe_if.slave): in_* handshake/operands, out_* handshake/result/flags.
module alu_cmp_pipe
   import alu_cmp_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   alu_cmp_pipe_if.slave bus
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       fun_q;
   logic             signed_q;

   logic             s2_valid_q, s2_valid_d;
   logic             cond_q, z_q, v_q, n_q, bad_q;

   logic             s2_load, s1_advance, in_ready, accept;
   logic             e_z, e_v, e_n, e_cond, e_bad;

   alu_cmp_eval #(.WIDTH(WIDTH)) u_eval (
      .a_i      (a_q),
      .b_i      (b_q),
      .fun_i    (fun_q),
      .signed_i (signed_q),
      .z_o      (e_z),
      .v_o      (e_v),
      .n_o      (e_n),
      .cond_o   (e_cond),
      .bad_o    (e_bad)
   );

   always_comb begin
      // S2 may take new data when empty or being drained this cycle.
      s2_load    = ~s2_valid_q | bus.out_ready;
      s1_advance = s1_valid_q & s2_load;
      in_ready   = ~s1_valid_q | s1_advance;
      accept     = bus.in_valid & in_ready;
      s1_valid_d = accept | (s1_valid_q & ~s1_advance);
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         fun_q      <= '0;
         signed_q   <= 1'b0;
         cond_q     <= 1'b0;
         z_q        <= 1'b0;
         v_q        <= 1'b0;
         n_q        <= 1'b0;
         bad_q      <= 1'b0;
      end else if (flush) begin
         // Squash only; stale data is harmless once the valid bits are clear.
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (accept) begin
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            fun_q    <= bus.in_fun;
            signed_q <= bus.in_signed;
         end
         if (s1_advance) begin
            cond_q <= e_cond;
            z_q    <= e_z;
            v_q    <= e_v;
            n_q    <= e_n;
            bad_q  <= e_bad;
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = s2_valid_q;
   assign bus.out_s       = {{(WIDTH-1){1'b0}}, cond_q};
   assign bus.out_z       = z_q;
   assign bus.out_v       = v_q;
   assign bus.out_n       = n_q;
   assign bus.out_bad_fun = bad_q;

endmodule

// File: tb/tb_alu_cmp_pipe.sv
// tb/tb_alu_cmp_pipe.sv - directed self-checking bench for alu_cmp_pipe
module tb_alu_cmp_pipe;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_cmp_pipe_if #(.WIDTH(32)) bus ();
   alu_cmp_pipe_if #(.WIDTH(8))  bus8 ();

   alu_cmp_pipe #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));
   alu_cmp_pipe #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .flush(flush), .bus(bus8));

   logic [31:0] ref_a, ref_b;
   logic [2:0]  ref_fun;
   logic        ref_signed, ref_z, ref_v, ref_n, ref_cond, ref_bad;

   alu_cmp_eval #(.WIDTH(32)) u_ref (
      .a_i(ref_a), .b_i(ref_b), .fun_i(ref_fun), .signed_i(ref_signed),
      .z_o(ref_z), .v_o(ref_v), .n_o(ref_n), .cond_o(ref_cond), .bad_o(ref_bad)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for one cycle with out_ready high, then waits for its result slot.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input logic s);
      bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_fun = f; bus.in_signed = s;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if ({bus.out_valid, bus.out_s, bus.out_z, bus.out_v, bus.out_n, bus.out_bad_fun} !== 37'd0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b s=%h z=%b v=%b n=%b bad=%b, want all 0",
                  bus.out_valid, bus.out_s, bus.out_z, bus.out_v, bus.out_n, bus.out_bad_fun);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_eval_ref();
      ref_a = 32'hFFFF_FFFF; ref_b = 32'd1; ref_fun = 3'b010; ref_signed = 1'b1;
      #1;
      checks++;
      if ({ref_cond, ref_n, ref_v, ref_bad} !== 4'b1100) begin
         errors++;
         $display("FAIL eval_signed_lt: got cond=%b n=%b v=%b bad=%b, want 1 1 0 0", ref_cond, ref_n, ref_v, ref_bad);
      end
      ref_signed = 1'b0;
      #1;
      checks++;
      if ({ref_cond, ref_n} !== 2'b00) begin
         errors++;
         $display("FAIL eval_unsigned_lt: got cond=%b n=%b, want 0 0", ref_cond, ref_n);
      end
   endtask

   task automatic test_signed_lt();
      // Presented in the cycle after edge k; result must show after edge k+2, not k+1.
      bus.in_valid = 1'b1; bus.in_a = 32'hFFFF_FFFF; bus.in_b = 32'd1; bus.in_fun = 3'b010; bus.in_signed = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got out_valid=%b after 1 edge, want 0", bus.out_valid);
      end
      tick();
      checks++;
      if ({bus.out_valid, bus.out_s, bus.out_n, bus.out_v, bus.out_z} !== {1'b1, 32'd1, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL signed_lt: got valid=%b s=%h n=%b v=%b z=%b, want 1 00000001 1 0 0",
                  bus.out_valid, bus.out_s, bus.out_n, bus.out_v, bus.out_z);
      end
   endtask

   task automatic test_unsigned_lt();
      issue(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0);
      checks++;
      if ({bus.out_valid, bus.out_s, bus.out_n, bus.out_v} !== {1'b1, 32'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL unsigned_lt: got valid=%b s=%h n=%b v=%b, want 1 00000000 0 0",
                  bus.out_valid, bus.out_s, bus.out_n, bus.out_v);
      end
   endtask

   task automatic test_overflow_and_zero_cmps();
      issue(32'h8000_0000, 32'd1, 3'b010, 1'b1);
      checks++;
      if ({bus.out_s, bus.out_n, bus.out_v} !== {32'd1, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL signed_lt_ovf: got s=%h n=%b v=%b, want 00000001 1 1", bus.out_s, bus.out_n, bus.out_v);
      end
      issue(32'h7FFF_FFFF, 32'hDEAD_BEEF, 3'b111, 1'b1);
      checks++;
      if ({bus.out_s, bus.out_z, bus.out_n} !== {32'd1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL signed_gtz: got s=%h z=%b n=%b, want 00000001 0 0", bus.out_s, bus.out_z, bus.out_n);
      end
      issue(32'hFFFF_FFFF, 32'd0, 3'b101, 1'b0);
      checks++;
      if (bus.out_s !== 32'd0) begin
         errors++;
         $display("FAIL unsigned_ltz: got s=%h, want 00000000", bus.out_s);
      end
      issue(32'd0, 32'd9, 3'b110, 1'b1);
      checks++;
      if ({bus.out_s, bus.out_z} !== {32'd1, 1'b1}) begin
         errors++;
         $display("FAIL signed_lez_zero: got s=%h z=%b, want 00000001 1", bus.out_s, bus.out_z);
      end
      issue(32'd5, 32'd5, 3'b011, 1'b1);
      checks++;
      if ({bus.out_valid, bus.out_s, bus.out_bad_fun, bus.out_z} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL bad_fun: got valid=%b s=%h bad=%b z=%b, want 1 00000000 1 1",
                  bus.out_valid, bus.out_s, bus.out_bad_fun, bus.out_z);
      end
   endtask

   task automatic test_width8();
      bus8.in_valid = 1'b1; bus8.in_a = 8'h00; bus8.in_b = 8'h55; bus8.in_fun = 3'b110; bus8.in_signed = 1'b0;
      tick();
      bus8.in_valid = 1'b0;
      tick();
      checks++;
      if ({bus8.out_valid, bus8.out_s, bus8.out_z} !== {1'b1, 8'h01, 1'b1}) begin
         errors++;
         $display("FAIL w8_unsigned_lez: got valid=%b s=%h z=%b, want 1 01 1", bus8.out_valid, bus8.out_s, bus8.out_z);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [8] = '{32'd5, 32'd5, 32'd7, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
      logic [31:0] vb [8] = '{32'd5, 32'd6, 32'd7, 32'd2, 32'd0, 32'd0, 32'd0, 32'd3};
      logic [2:0]  vf [8] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001, 3'b000};
      logic        es [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic        ez [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic prev_stall = 1'b0;
      logic [31:0] prev_s = '0;
      logic prev_z = 1'b0;
      while (got < 8 && cyc < 200) begin
         bus.out_ready = pat[cyc % 4];
         bus.in_valid  = (sent < 8);
         if (sent < 8) begin
            bus.in_a = va[sent]; bus.in_b = vb[sent]; bus.in_fun = vf[sent]; bus.in_signed = sent[0];
         end
         #1;
         checks++;
         if (bus.in_ready !== ((sent - got) < 2 || bus.out_ready)) begin
            errors++;
            $display("FAIL b2b_in_ready cyc=%0d: got %b, want %b (in flight %0d, out_ready %b)",
                     cyc, bus.in_ready, ((sent - got) < 2 || bus.out_ready), sent - got, bus.out_ready);
         end
         if (prev_stall) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_s !== prev_s || bus.out_z !== prev_z) begin
               errors++;
               $display("FAIL b2b_stall_hold cyc=%0d: got valid=%b s=%h z=%b, want 1 %h %b",
                        cyc, bus.out_valid, bus.out_s, bus.out_z, prev_s, prev_z);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (bus.out_s !== {31'd0, es[got]} || bus.out_z !== ez[got]) begin
               errors++;
               $display("FAIL b2b_result #%0d: got s=%h z=%b, want %h %b", got, bus.out_s, bus.out_z, {31'd0, es[got]}, ez[got]);
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) sent++;
         prev_stall = bus.out_valid & ~bus.out_ready;
         prev_s = bus.out_s;
         prev_z = bus.out_z;
         @(posedge clk);
         #1;
         cyc++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      checks++;
      if (got != 8) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want 8 (cycle budget hit)", got);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_dup: got out_valid=%b after drain, want 0", bus.out_valid);
      end
   endtask

   task automatic fill_both(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input logic s);
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_fun = f; bus.in_signed = s;
      tick();
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic test_flush();
      fill_both(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_full: got out_valid=%b in_ready=%b, want 1 0", bus.out_valid, bus.in_ready);
      end
      flush = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_a = 32'd4; bus.in_b = 32'd4; bus.in_fun = 3'b001; bus.in_signed = 1'b0;
      tick();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_clear: got out_valid=%b, want 0", bus.out_valid);
      end
      tick(); tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop_input: got out_valid=%b, want 0", bus.out_valid);
      end
      bus.in_valid = 1'b1; bus.in_a = 32'd1; bus.in_b = 32'd0; bus.in_fun = 3'b111; bus.in_signed = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_ready: got in_ready=%b, want 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_next_early: got out_valid=%b, want 0", bus.out_valid);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_s !== 32'd1) begin
         errors++;
         $display("FAIL flush_next_op: got valid=%b s=%h, want 1 00000001", bus.out_valid, bus.out_s);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      fill_both(32'h8000_0000, 32'd1, 3'b010, 1'b1);
      checks++;
      if (bus.out_s !== 32'd1 || bus.out_v !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_pre: got s=%h v=%b, want 00000001 1", bus.out_s, bus.out_v);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({bus.out_valid, bus.out_s, bus.out_z, bus.out_v, bus.out_n, bus.out_bad_fun, bus.in_ready} !== {37'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_mid: got valid=%b s=%h z=%b v=%b n=%b bad=%b in_ready=%b, want all 0, in_ready 1",
                  bus.out_valid, bus.out_s, bus.out_z, bus.out_v, bus.out_n, bus.out_bad_fun, bus.in_ready);
      end
      tick();
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_fun = '0; bus.in_signed = 1'b0; bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.in_a = '0; bus8.in_b = '0; bus8.in_fun = '0; bus8.in_signed = 1'b0; bus8.out_ready = 1'b1;
      ref_a = '0; ref_b = '0; ref_fun = '0; ref_signed = 1'b0;
      test_reset();
      test_eval_ref();
      test_signed_lt();
      test_unsigned_lt();
      test_overflow_and_zero_cmps();
      test_width8();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
